uart_tx_regfile: RTL and testbench

//  Memory-mapped UART transmit register file on the core's data bus; next generation of the UART register block.

---
 rtl/uart_tx_regfile.sv | 145 ++++++++++++++
 tb/tb_uart_tx_regfile.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_regfile.sv
// uart_tx_regfile
//   Memory-mapped UART transmit register block. Software pushes bytes into a
//   small TX FIFO; a two-state sequencer hands them to the transmitter one at
//   a time using a start/done handshake.
//
//   Ports
//     clk, rst      system clock, synchronous active-high reset
//     write_enable  bus write strobe
//     address       byte address, word index = address[4:2]
//     data_in       bus write data
//     data_rd       bus read data (combinational from address)
//     dvsr          baud divisor to the transmitter
//     tx_data       byte presented to the transmitter
//     tx_start      one-cycle start pulse to the transmitter
//     tx_done       one-cycle "byte finished" pulse from the transmitter
//     irq_empty     level: FIFO empty and sequencer idle
//
//   Word map: 0 TXDATA, 1 DVSR, 2 CTRL (bit0 tx_en),
//             3 STATUS (bit0 empty, bit1 full, bit2 busy, bit3 ovf, [8:4] count)
module uart_tx_regfile #(
    parameter int                DATA_W     = 32,
    parameter int                DVSR_W     = 11,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [DVSR_W-1:0] DVSR_RST   = 11'd325
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_enable,
    input  logic [4:0]        address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_rd,
    output logic [DVSR_W-1:0] dvsr,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_done,
    output logic              irq_empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               ovf;
    logic               tx_en;

    logic [2:0]         idx;
    logic               empty;
    logic               full;
    logic               busy;
    logic               push_req;
    logic               push_ok;
    logic               push_drop;
    logic               pop;
    logic [4:0]         count_ext;
    logic               unused_bits;

    assign idx       = address[4:2];
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign busy      = (state == BUSY);
    assign count_ext = 5'(count);

    // A byte is popped either when idle, or directly on the tx_done edge so
    // back-to-back bytes start the cycle after the previous one finishes.
    assign pop = tx_en && !empty && ((state == IDLE) || tx_done);

    // A pop on the same edge frees a slot, so a push to a full FIFO succeeds.
    assign push_req  = write_enable && (idx == 3'd0);
    assign push_ok   = push_req && (!full || pop);
    assign push_drop = push_req && full && !pop;

    assign irq_empty = empty && (state == IDLE);

    assign unused_bits = ^{address[1:0], data_in[DATA_W-1:DVSR_W]};

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            tx_en    <= 1'b0;
            dvsr     <= DVSR_RST;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                tx_data <= mem[rd_ptr];
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (push_drop) begin
                ovf <= 1'b1;
            end else if (write_enable && (idx == 3'd3) && data_in[3]) begin
                ovf <= 1'b0;
            end

            if (write_enable && (idx == 3'd1)) begin
                dvsr <= data_in[DVSR_W-1:0];
            end
            if (write_enable && (idx == 3'd2)) begin
                tx_en <= data_in[0];
            end

            tx_start <= pop;
            case (state)
                IDLE: if (pop) state <= BUSY;
                BUSY: if (tx_done && !pop) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        data_rd = '0;
        case (idx)
            3'd1: data_rd[DVSR_W-1:0] = dvsr;
            3'd2: data_rd[0]          = tx_en;
            3'd3: data_rd[8:0]        = {count_ext, ovf, busy, full, empty};
            default: data_rd = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_regfile.sv
module tb_uart_tx_regfile;

    localparam int DATA_W = 32;
    localparam int DVSR_W = 11;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              write_enable = 1'b0;
    logic [4:0]        address = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic [DATA_W-1:0] data_rd;
    logic [DVSR_W-1:0] dvsr;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_done = 1'b0;
    logic              irq_empty;

    uart_tx_regfile #(
        .DATA_W    (DATA_W),
        .DVSR_W    (DVSR_W),
        .FIFO_DEPTH(DEPTH),
        .DVSR_RST  (11'd325)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .write_enable(write_enable),
        .address     (address),
        .data_in     (data_in),
        .data_rd     (data_rd),
        .dvsr        (dvsr),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .irq_empty   (irq_empty)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: the FIFO is a plain queue of bytes.
    logic [7:0]        fifo_q[$];
    bit                m_en, m_busy, m_ovf;
    logic [DVSR_W-1:0] m_dvsr;
    logic [7:0]        m_txd;

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;
    exp_t exp_q[$];
    int   start_cycs[$];

    bit mon_on  = 1'b0;
    bit auto_tx = 1'b0;
    int cd      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every cycle either the head expectation is due
    // (start pulse with the predicted byte) or tx_start must be low.
    always @(negedge clk) begin
        if (mon_on) begin
            if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
                chk("tx_start_due", 32'(tx_start), 32'd1);
                chk("tx_data_order", 32'(tx_data), 32'(exp_q[0].d));
                void'(exp_q.pop_front());
            end else begin
                chk("tx_start_idle", 32'(tx_start), 32'd0);
            end
            if (tx_start === 1'b1) start_cycs.push_back(cyc);
        end
    end

    task automatic model(input bit r, input bit we, input logic [4:0] a,
                         input logic [31:0] d, input bit dn);
        int  i;
        bit  was_full;
        bit  popped;
        if (r) begin
            fifo_q.delete();
            m_en = 0; m_busy = 0; m_ovf = 0; m_dvsr = 11'd325; m_txd = 8'h00;
            cd = 0;
            return;
        end
        i        = int'(a) / 4;
        was_full = (fifo_q.size() == DEPTH);
        popped   = m_en && fifo_q.size() > 0 && (!m_busy || dn);
        if (popped) begin
            m_txd  = fifo_q.pop_front();
            exp_q.push_back('{d: m_txd, c: cyc + 1});
            m_busy = 1;
            if (auto_tx) cd = 11;
        end else if (m_busy && dn) begin
            m_busy = 0;
        end
        if (we) begin
            case (i)
                0: if (!was_full || popped) fifo_q.push_back(d[7:0]); else m_ovf = 1;
                1: m_dvsr = d[DVSR_W-1:0];
                2: m_en = d[0];
                3: if (d[3]) m_ovf = 0;
                default: ;
            endcase
        end
    endtask

    task automatic check_regs();
        logic [31:0] st;
        bit emp, ful;
        emp = (fifo_q.size() == 0);
        ful = (fifo_q.size() == DEPTH);
        st  = 32'({5'(fifo_q.size()), m_ovf, m_busy, ful, emp});
        write_enable = 1'b0;
        address = 5'd12; #1 chk("STATUS", data_rd, st);
        address = 5'd4;  #1 chk("DVSR_rd", data_rd, 32'(m_dvsr));
        address = 5'd8;  #1 chk("CTRL", data_rd, 32'(m_en));
        chk("dvsr_port", 32'(dvsr), 32'(m_dvsr));
        chk("irq_empty", 32'(irq_empty), 32'(emp && !m_busy));
        chk("tx_data_hold", 32'(tx_data), 32'(m_txd));
    endtask

    task automatic step(input bit r, input bit we, input logic [4:0] a,
                        input logic [31:0] d, input bit dn_in);
        bit dn;
        dn = dn_in;
        if (cd > 0) begin
            cd--;
            if (cd == 0) dn = 1;
        end
        rst = r; write_enable = we; address = a; data_in = d; tx_done = dn;
        model(r, we, a, d, dn);
        @(posedge clk); #1;
        check_regs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 5'd0, 32'd0, 0);
    endtask

    task automatic push(input logic [7:0] b);
        step(0, 1, 5'd0, 32'(b), 0);
    endtask

    initial begin
        int v;
        logic [4:0] a;
        logic [31:0] d;

        // Reset state
        model(1, 0, 5'd0, 32'd0, 0);
        @(posedge clk); #1;
        step(1, 0, 5'd0, 32'd0, 0);
        mon_on = 1'b1;
        address = 5'd0;  #1 chk("TXDATA_rd", data_rd, 32'd0);
        address = 5'd20; #1 chk("unused_rd", data_rd, 32'd0);
        chk("tx_start_rst", 32'(tx_start), 32'd0);

        // Queue with tx_en=0, then enable
        push(8'h41); push(8'h42);
        idle(3);
        step(0, 1, 5'd8, 32'd1, 0);
        idle(4);
        step(0, 0, 5'd0, 32'd0, 1);
        idle(4);
        step(0, 0, 5'd0, 32'd0, 1);
        idle(3);
        step(0, 0, 5'd0, 32'd0, 1);   // stray done in IDLE
        idle(2);

        // Overflow and sticky clear
        step(1, 0, 5'd0, 32'd0, 0);
        for (int k = 0; k < 5; k++) push(8'(8'h41 + k));
        step(0, 1, 5'd20, 32'hFF, 0);  // unused index write ignored
        step(0, 1, 5'd13, 32'h8, 0);   // low address bits do not matter
        idle(1);

        // Three bytes, done 10 cycles after each start
        step(1, 0, 5'd0, 32'd0, 0);
        auto_tx = 1'b1;
        start_cycs.delete();
        step(0, 1, 5'd8, 32'd1, 0);
        push(8'hA1); push(8'hA2); push(8'hA3);
        idle(40);
        chk("n_starts", 32'(start_cycs.size()), 32'd3);
        if (start_cycs.size() == 3) begin
            chk("spacing1", 32'(start_cycs[1] - start_cycs[0]), 32'd11);
            chk("spacing2", 32'(start_cycs[2] - start_cycs[1]), 32'd11);
        end

        // Full FIFO, push on the tx_done->pop edge
        auto_tx = 1'b0;
        cd = 0;
        step(1, 0, 5'd0, 32'd0, 0);
        step(0, 1, 5'd8, 32'd1, 0);
        push(8'hB0);
        push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
        step(0, 1, 5'd4, 32'h7A5, 0);  // DVSR write while busy
        step(0, 1, 5'd0, 32'hB5, 1);   // push + done same edge
        idle(2);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 5'd0, 32'd0, 1);
            idle(2);
        end

        // Reset mid-transfer with two queued bytes
        step(0, 1, 5'd8, 32'd1, 0);
        push(8'hC0); push(8'hC1); push(8'hC2);
        idle(2);
        step(1, 0, 5'd0, 32'd0, 0);
        idle(2);
        step(0, 0, 5'd0, 32'd0, 1);
        idle(4);

        // Randomized traffic
        auto_tx = 1'b1;
        step(0, 1, 5'd8, 32'd1, 0);
        for (int k = 0; k < 400; k++) begin
            v = $urandom_range(0, 99);
            d = $urandom;
            a = {3'd0, 2'($urandom)};
            if (v < 35)      a[4:2] = 3'd0;
            else if (v < 40) begin a[4:2] = 3'd2; d[0] = ($urandom_range(0, 3) != 0); end
            else if (v < 45) a[4:2] = 3'd3;
            else if (v < 48) a[4:2] = 3'd1;
            else if (v < 51) a[4:2] = 3'($urandom_range(4, 7));
            if (v == 99)     step(1, 0, a, d, 0);
            else if (v < 51) step(0, 1, a, d, ($urandom_range(0, 49) == 0));
            else             step(0, 0, a, d, ($urandom_range(0, 49) == 0));
        end

        // Drain
        step(0, 1, 5'd8, 32'd1, 0);
        idle(60);
        chk("drain_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
